// File: rtl/muldiv_sequencer.sv
// Iterative 32x32 multiply / 32/32 divide unit for the Execute stage.
// One radix-2 step per cycle; signed ops run on magnitudes and fix signs on the final step.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ResultLo,
  output logic [31:0] ResultHi,
  output logic        DivByZero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic        is_div_q;
  logic        neg_lo_q;
  logic        neg_hi_q;
  logic [31:0] opnd_q;
  logic [63:0] prod_q;
  logic [32:0] rem_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        dbz_q;

  logic        accept;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        q_bit;
  logic [63:0] prod_d;
  logic [32:0] rem_d;
  logic [63:0] mul_res;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  always_comb begin
    accept  = StartE && (state_q != BUSY) && !FlushE;
    // Negating 0x80000000 wraps back to itself, which is the correct unsigned magnitude.
    mag_a   = (OpE[0] && SrcAE[31]) ? -SrcAE : SrcAE;
    mag_b   = (OpE[0] && SrcBE[31]) ? -SrcBE : SrcBE;

    mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Dividend bits shift out of prod_q[31:0] while quotient bits shift in from the bottom.
    rem_sh  = {rem_q[31:0], prod_q[31]};
    diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
    q_bit   = ~diff[33];

    prod_d  = prod_q;
    rem_d   = rem_q;
    if (is_div_q) begin
      prod_d = {prod_q[63:32], prod_q[30:0], q_bit};
      rem_d  = q_bit ? diff[32:0] : rem_sh;
    end else begin
      prod_d = {mul_sum, prod_q[31:1]};
    end

    mul_res = neg_lo_q ? -prod_d : prod_d;
    div_lo  = neg_lo_q ? -prod_d[31:0] : prod_d[31:0];
    div_hi  = neg_hi_q ? -rem_d[31:0] : rem_d[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= 32'd0;
      prod_q   <= 64'd0;
      rem_q    <= 33'd0;
      lo_q     <= 32'd0;
      hi_q     <= 32'd0;
      dbz_q    <= 1'b0;
    end else if (FlushE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        BUSY: begin
          prod_q  <= prod_d;
          rem_q   <= rem_d;
          count_q <= count_q - 5'd1;
          if (count_q == 5'd0) begin
            state_q <= DONE;
            lo_q    <= is_div_q ? div_lo : mul_res[31:0];
            hi_q    <= is_div_q ? div_hi : mul_res[63:32];
          end
        end
        default: begin
          if (accept) begin
            is_div_q <= OpE[1];
            count_q  <= 5'd31;
            rem_q    <= 33'd0;
            dbz_q    <= 1'b0;
            neg_lo_q <= OpE[0] & (SrcAE[31] ^ SrcBE[31]);
            neg_hi_q <= OpE[0] & SrcAE[31];
            if (OpE[1]) begin
              opnd_q <= mag_b;
              prod_q <= {32'd0, mag_a};
              if (SrcBE == 32'd0) begin
                state_q <= DONE;
                lo_q    <= 32'd0;
                hi_q    <= SrcAE;
                dbz_q   <= 1'b1;
              end else begin
                state_q <= BUSY;
              end
            end else begin
              opnd_q  <= mag_a;
              prod_q  <= {32'd0, mag_b};
              state_q <= BUSY;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign Busy      = (state_q == BUSY);
  assign Done      = (state_q == DONE);
  assign StallE    = accept || (state_q == BUSY);
  assign ResultLo  = lo_q;
  assign ResultHi  = hi_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are computed with native
// 64-bit arithmetic at launch and compared when Done appears.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StartE = 1'b0;
  logic [1:0]  OpE = 2'b00;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        FlushE = 1'b0;
  logic        StallE, Busy, Done, DivByZero;
  logic [31:0] ResultLo, ResultHi;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  logic [31:0] last_lo, last_hi;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .FlushE(FlushE), .StallE(StallE), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.lat = 33;
    case (op)
      2'b00: begin u = {32'd0, a} * {32'd0, b}; e.lo = u[31:0]; e.hi = u[63:32]; end
      2'b01: begin p = sa * sb; e.lo = p[31:0]; e.hi = p[63:32]; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'd0; e.hi = a; e.dz = 1'b1; e.lat = 1;
        end else if (op == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; leaves control one step after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    #1;
    checks++;
    if (StallE !== 1'b1) begin
      failures++;
      $display("FAIL stall_on_accept: got %b expected 1", StallE);
    end
    if (track) sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    StartE = 1'b0;
  endtask

  // Waits for Done (bounded); optionally pokes StartE with junk at cycle poke while busy.
  task automatic expect_done(input int poke);
    exp_t e;
    bit seen = 1'b0;
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n = i;
      if (StartE) StartE = 1'b0;
      if (Done === 1'b1) begin seen = 1'b1; break; end
      checks++;
      if (Busy !== 1'b1 || StallE !== 1'b1) begin
        failures++;
        $display("FAIL busy_stall cycle %0d: got busy=%b stall=%b expected 1/1", i, Busy, StallE);
      end
      if (i == poke) begin
        StartE = 1'b1; OpE = 2'b01; SrcAE = 32'h1234_5678; SrcBE = 32'h8765_4321;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: got no Done expected Done within 40 cycles");
      return;
    end
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_done: got Done expected none pending");
      return;
    end
    e = sb_q.pop_front();
    last_lo = e.lo;
    last_hi = e.hi;
    $display("txn lo=%h hi=%h dz=%b lat=%0d (exp lo=%h hi=%h dz=%b lat=%0d)",
             ResultLo, ResultHi, DivByZero, n, e.lo, e.hi, e.dz, e.lat);
    checks++;
    if (n != e.lat) begin failures++; $display("FAIL latency: got %0d expected %0d", n, e.lat); end
    checks++;
    if (ResultLo !== e.lo) begin failures++; $display("FAIL result_lo: got %h expected %h", ResultLo, e.lo); end
    checks++;
    if (ResultHi !== e.hi) begin failures++; $display("FAIL result_hi: got %h expected %h", ResultHi, e.hi); end
    checks++;
    if (DivByZero !== e.dz) begin failures++; $display("FAIL div_by_zero: got %b expected %b", DivByZero, e.dz); end
    checks++;
    if (Busy !== 1'b0 || StallE !== 1'b0) begin
      failures++;
      $display("FAIL done_busy_stall: got busy=%b stall=%b expected 0/0", Busy, StallE);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({Busy, Done, DivByZero, StallE} !== 4'b0 || ResultLo !== 32'd0 || ResultHi !== 32'd0) begin
      failures++;
      $display("FAIL %s: got busy=%b done=%b dz=%b stall=%b lo=%h hi=%h expected all 0",
               name, Busy, Done, DivByZero, StallE, ResultLo, ResultHi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_state");
  endtask

  task automatic test_umull();
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    expect_done(0);
    repeat (3) @(negedge clk);
    checks++;
    if (Done !== 1'b0 || ResultLo !== last_lo || ResultHi !== last_hi) begin
      failures++;
      $display("FAIL result_hold: got done=%b lo=%h hi=%h expected 0 %h %h", Done, ResultLo, ResultHi, last_lo, last_hi);
    end
  endtask

  task automatic test_smull();
    launch(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1);
    expect_done(0);
    @(negedge clk);
  endtask

  task automatic test_div();
    launch(2'b10, 32'd100, 32'd7, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b1);
    expect_done(0);
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    launch(2'b10, 32'd5, 32'd0, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b11, 32'hFFFF_FF00, 32'd0, 1'b1);
    expect_done(0);
    @(negedge clk);
    launch(2'b00, 32'd6, 32'd7, 1'b1);
    expect_done(0);
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    launch(2'b10, 32'd100, 32'd7, 1'b1);
    expect_done(5);
    @(negedge clk);
  endtask

  task automatic test_flush();
    launch(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (10) @(negedge clk);
    FlushE = 1'b1;
    @(posedge clk);
    #1;
    FlushE = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || StallE !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL flush_abort: got busy=%b stall=%b done=%b expected 0/0/0", Busy, StallE, Done);
    end
    @(negedge clk);
    launch(2'b00, 32'd40000, 32'd70000, 1'b1);
    expect_done(0);
    @(negedge clk);
  endtask

  task automatic test_start_flush_same_cycle();
    StartE = 1'b1; FlushE = 1'b1; OpE = 2'b00; SrcAE = 32'd3; SrcBE = 32'd4;
    #1;
    checks++;
    if (StallE !== 1'b0) begin failures++; $display("FAIL flush_wins_stall: got %b expected 0", StallE); end
    @(posedge clk);
    #1;
    StartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL flush_wins_state: got busy=%b done=%b expected 0/0", Busy, Done);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    launch(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expect_done(0);
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if (k == 7) begin op = 2'b11; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      launch(op, a, b, 1'b1);
    end
    expect_done(0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    launch(2'b11, 32'hFFFF_0000, 32'd3, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_op");
  endtask

  initial begin
    test_reset();
    test_umull();
    test_smull();
    test_div();
    test_div_by_zero();
    test_start_while_busy();
    test_flush();
    test_start_flush_same_cycle();
    test_back_to_back();
    test_reset_mid_op();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk, input, 1, rising-edge clock.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: StartE, input, 1, request to launch an operation from the Execute stage.
REQ-005 Port: OpE, input, 2, operation code: 00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV.
REQ-006 Port: SrcAE, input, 32, multiplicand or dividend.
REQ-007 Port: SrcBE, input, 32, multiplier or divisor.
REQ-008 Port: FlushE, input, 1, abort of the in-flight operation.
REQ-009 Port: StallE, output, 1, holds the pipeline Fetch, Decode and Execute stages.
REQ-010 Port: Busy, output, 1, high while an iterative operation is in progress.
REQ-011 Port: Done, output, 1, single-cycle result-valid strobe.
REQ-012 Port: ResultLo, output, 32, product bits [31:0] for MUL ops, or quotient for DIV ops.
REQ-013 Port: ResultHi, output, 32, product bits [63:32] for MUL ops, or remainder for DIV ops.
REQ-014 Port: DivByZero, output, 1, set with Done when a DIV op has SrcBE equal to 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 Accept condition: StartE=1 while the state is IDLE or DONE, and FlushE=0.
REQ-017 On accept, the block SHALL latch OpE, SrcAE and SrcBE.
REQ-018 On accept, the 5-bit iteration counter SHALL load 31.
REQ-019 On accept the next state SHALL be BUSY, or DONE directly if the op is a DIV with SrcBE=0.
REQ-020 BUSY SHALL perform one radix-2 step per cycle: shift-add for MUL, restoring subtract for DIV.
REQ-021 BUSY SHALL decrement the counter each cycle and go to DONE after the step at count 0 (exactly 32 BUSY cycles).
REQ-022 DONE SHALL last one cycle with Done=1 and results stable; the next state is IDLE unless a new accept occurs.
REQ-023 Latency: accept at edge 0 gives BUSY in cycles 1..32 and Done=1 in cycle 33.
REQ-024 Latency for divide-by-zero: Done=1 in cycle 1.
REQ-025 Busy SHALL be 1 only in the BUSY state.
REQ-026 StallE SHALL be (accept condition) OR (state==BUSY), combinational.
REQ-027 StallE SHALL be 0 in DONE so the pipeline captures the result.
REQ-028 StartE while BUSY SHALL be ignored, with no effect on state or operands.
REQ-029 Signed ops SHALL operate on operand magnitudes.
REQ-030 SMULL SHALL negate the 64-bit product when the operand signs differ.
REQ-031 SDIV SHALL negate the quotient when the signs differ, and give the remainder the sign of the dividend.
REQ-032 SDIV 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no flag).
REQ-033 The magnitude of 0x80000000 SHALL be treated as unsigned 0x80000000.
REQ-034 Divide-by-zero result: ResultLo=0, ResultHi=dividend (raw SrcAE), DivByZero=1.
REQ-035 DivByZero SHALL be 0 for every other result.
REQ-036 Results and DivByZero SHALL hold their values after DONE until the next accept or reset.
REQ-037 FlushE=1 in any state SHALL force next state IDLE, suppress Done, and block any accept in the same cycle.
REQ-038 Simultaneous StartE and FlushE SHALL resolve as flush wins.
REQ-039 Arithmetic: 64-bit product register, 33-bit partial remainder; all results are modulo 2^32 per word.

Reset
REQ-040 reset=1 at a rising edge SHALL force state IDLE and counter 0, from any state including mid-BUSY.
REQ-041 Reset SHALL clear Busy, Done, DivByZero, ResultLo and ResultHi to 0.
REQ-042 StallE SHALL be 0 in the cycle after reset, unless StartE=1.
REQ-043 reset SHALL take priority over StartE and FlushE.

Verification
REQ-044 UMULL 0xFFFFFFFF x 0xFFFFFFFF -> Done=1 in cycle 33, ResultHi=0xFFFFFFFE, ResultLo=0x00000001; StallE=1 in cycles 0..32 and 0 in cycle 33.
REQ-045 SMULL 0xFFFFFFFE x 3 -> cycle 33: ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFA.
REQ-046 UDIV 100/7 -> cycle 33: ResultLo=14, ResultHi=2; SDIV 0xFFFFFFF9/2 -> ResultLo=0xFFFFFFFD, ResultHi=0xFFFFFFFF.
REQ-047 UDIV 5/0 -> cycle 1: Done=1, DivByZero=1, ResultLo=0, ResultHi=5, Busy never 1.
REQ-048 UMULL started, FlushE=1 in cycle 10 -> Busy=0 and StallE=0 from cycle 11, Done never asserts; StartE in cycle 12 is accepted normally.
REQ-049 Reset in cycle 20 of an SDIV -> all outputs 0 next cycle; back-to-back StartE in DONE -> second Done exactly 33 cycles after the first.
